// File: rtl/div36x18_seq.sv
// rtl/div36x18_seq.sv - sequential 36/18 restoring divider, fixed 19-edge latency
// Signed operands are divided as magnitudes; sign fix-up and saturation happen in FIX.
module div36x18_seq #(
    parameter string GSR = "ENABLED"
) (
    input  logic        CLK0,
    input  logic        RST0,
    input  logic        CE0,
    input  logic        START,
    input  logic        SIGNED,
    input  logic [35:0] DIVIDEND,
    input  logic [17:0] DIVISOR,
    output logic        BUSY,
    output logic        DONE,
    output logic [17:0] Q,
    output logic [17:0] R,
    output logic        DIV_ZERO,
    output logic        OVERFLOW,
    output logic        SIGNEDQ
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    typedef struct packed {
        logic [17:0] rem;
        logic [17:0] low;
        logic [17:0] quo;
        logic [17:0] dvs_mag;
        logic [17:0] raw_lo;
        logic        sgn;
        logic        dvd_neg;
        logic        dvs_neg;
        logic        mag_ovf;
        logic [17:0] q;
        logic [17:0] r;
        logic        div_zero;
        logic        ovf;
        logic        signedq;
    } dp_t;

    state_t      state_q, state_n;
    logic [4:0]  cnt_q, cnt_n;
    dp_t         dp, dp_n;

    logic [35:0] dvd_abs;
    logic [17:0] dvs_abs;
    logic [18:0] shifted;
    logic        fits;
    logic        q_neg;
    logic        sgn_ovf;
    logic [17:0] ovf_sat;
    logic [17:0] dz_sat;

    always_ff @(posedge CLK0 or posedge RST0) begin
        if (RST0) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        if (CE0) begin
            case (state_q)
                S_IDLE: if (START) begin
                    state_n = S_CALC;
                    cnt_n   = '0;
                end
                S_CALC: begin
                    cnt_n = cnt_q + 5'd1;
                    if (cnt_q == 5'd17) state_n = S_FIX;
                end
                S_FIX:   state_n = S_DONE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_comb begin
        dvd_abs = (SIGNED && DIVIDEND[35]) ? (36'd0 - DIVIDEND) : DIVIDEND;
        dvs_abs = (SIGNED && DIVISOR[17]) ? (18'd0 - DIVISOR) : DIVISOR;
        // Partial remainder stays below the divisor once magnitude overflow is excluded,
        // so 18 bits of remainder plus the incoming dividend bit suffice.
        shifted = {dp.rem, dp.low[17]};
        fits    = shifted >= {1'b0, dp.dvs_mag};
        q_neg   = dp.sgn & (dp.dvd_neg ^ dp.dvs_neg);
        sgn_ovf = dp.sgn & (q_neg ? (dp.quo > 18'h20000) : (dp.quo > 18'h1FFFF));
        ovf_sat = !dp.sgn ? 18'h3FFFF : (q_neg ? 18'h20000 : 18'h1FFFF);
        dz_sat  = !dp.sgn ? 18'h3FFFF : (dp.dvd_neg ? 18'h20000 : 18'h1FFFF);

        dp_n = dp;
        if (CE0) begin
            case (state_q)
                S_IDLE: if (START) begin
                    dp_n.sgn     = SIGNED;
                    dp_n.dvd_neg = SIGNED & DIVIDEND[35];
                    dp_n.dvs_neg = SIGNED & DIVISOR[17];
                    dp_n.rem     = dvd_abs[35:18];
                    dp_n.low     = dvd_abs[17:0];
                    dp_n.quo     = '0;
                    dp_n.dvs_mag = dvs_abs;
                    dp_n.raw_lo  = DIVIDEND[17:0];
                    dp_n.mag_ovf = dvd_abs[35:18] >= dvs_abs;
                end
                S_CALC: begin
                    dp_n.rem = fits ? (shifted[17:0] - dp.dvs_mag) : shifted[17:0];
                    dp_n.low = {dp.low[16:0], 1'b0};
                    dp_n.quo = {dp.quo[16:0], fits};
                end
                S_FIX: begin
                    dp_n.signedq = dp.sgn;
                    if (dp.dvs_mag == 18'd0) begin
                        dp_n.div_zero = 1'b1;
                        dp_n.ovf      = 1'b0;
                        dp_n.q        = dz_sat;
                        dp_n.r        = dp.raw_lo;
                    end else if (dp.mag_ovf || sgn_ovf) begin
                        dp_n.div_zero = 1'b0;
                        dp_n.ovf      = 1'b1;
                        dp_n.q        = ovf_sat;
                        dp_n.r        = '0;
                    end else begin
                        dp_n.div_zero = 1'b0;
                        dp_n.ovf      = 1'b0;
                        dp_n.q        = q_neg ? (18'd0 - dp.quo) : dp.quo;
                        dp_n.r        = dp.dvd_neg ? (18'd0 - dp.rem) : dp.rem;
                    end
                end
                default: ;
            endcase
        end
    end

    generate
        if (GSR == "ENABLED") begin : g_gsr_on
            always_ff @(posedge CLK0 or posedge RST0) begin
                if (RST0) dp <= '0;
                else      dp <= dp_n;
            end
        end else begin : g_gsr_off
            always_ff @(posedge CLK0) begin
                if (!RST0) dp <= dp_n;
            end
        end
    endgenerate

    assign BUSY     = (state_q == S_CALC) || (state_q == S_FIX);
    assign DONE     = (state_q == S_DONE);
    assign Q        = dp.q;
    assign R        = dp.r;
    assign DIV_ZERO = dp.div_zero;
    assign OVERFLOW = dp.ovf;
    assign SIGNEDQ  = dp.signedq;

endmodule

// File: tb/tb_div36x18_seq.sv
// tb/tb_div36x18_seq.sv - directed-vector bench for div36x18_seq with arithmetic reference model
module tb_div36x18_seq;

    logic        CLK0 = 1'b0;
    logic        RST0;
    logic        CE0;
    logic        START;
    logic        SIGNED;
    logic [35:0] DIVIDEND;
    logic [17:0] DIVISOR;
    logic        BUSY;
    logic        DONE;
    logic [17:0] Q;
    logic [17:0] R;
    logic        DIV_ZERO;
    logic        OVERFLOW;
    logic        SIGNEDQ;

    div36x18_seq dut (
        .CLK0(CLK0), .RST0(RST0), .CE0(CE0), .START(START), .SIGNED(SIGNED),
        .DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR), .BUSY(BUSY), .DONE(DONE),
        .Q(Q), .R(R), .DIV_ZERO(DIV_ZERO), .OVERFLOW(OVERFLOW), .SIGNEDQ(SIGNEDQ)
    );

    always #5 CLK0 = ~CLK0;

    typedef struct packed {
        logic [17:0] q;
        logic [17:0] r;
        logic        dz;
        logic        ovf;
        logic        sq;
    } res_t;

    typedef struct {
        logic [35:0] a;
        logic [17:0] b;
        logic        s;
        res_t        e;
    } vec_t;

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    res_t exp_q[$];
    res_t cur       = '0;
    bit   cmp_en    = 1'b0;
    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Reference: plain integer division on the operand values, then range saturation.
    function automatic res_t model(input logic [35:0] a, input logic [17:0] b, input logic s);
        res_t   e;
        longint na, nb, qq, rr;
        e = '0;
        e.sq = s;
        if (s) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({28'd0, a});
            nb = longint'({46'd0, b});
        end
        if (nb == 0) begin
            e.dz = 1'b1;
            e.r  = a[17:0];
            e.q  = !s ? 18'h3FFFF : (na < 0 ? 18'h20000 : 18'h1FFFF);
        end else begin
            qq = na / nb;
            rr = na % nb;
            if ((!s && qq > 262143) || (s && (qq > 131071 || qq < -131072))) begin
                e.ovf = 1'b1;
                e.r   = '0;
                e.q   = !s ? 18'h3FFFF : (qq > 0 ? 18'h1FFFF : 18'h20000);
            end else begin
                e.q = qq[17:0];
                e.r = rr[17:0];
            end
        end
        return e;
    endfunction

    task automatic add(input logic [35:0] a, input logic [17:0] b, input logic s,
                       input logic [17:0] q, input logic [17:0] r, input logic dz, input logic ovf);
        vec_t v;
        v.a = a; v.b = b; v.s = s;
        v.e = '{q: q, r: r, dz: dz, ovf: ovf, sq: s};
        vecs.push_back(v);
    endtask

    always @(negedge CLK0) begin
        if (!RST0 && cmp_en) begin
            if (DONE) begin
                chk("done_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) cur = exp_q.pop_front();
            end
            chk("outputs", {Q, R, DIV_ZERO, OVERFLOW, SIGNEDQ}, cur);
        end
    end

    task automatic run_op(input logic [35:0] a, input logic [17:0] b, input logic s,
                          input int stall_at, input int stall_len, input bit hold_start);
        int edges;
        @(negedge CLK0);
        DIVIDEND = a; DIVISOR = b; SIGNED = s; START = 1'b1;
        exp_q.push_back(model(a, b, s));
        @(posedge CLK0);
        if (!hold_start) #1 START = 1'b0;
        edges = 0;
        while (edges < 60) begin
            @(negedge CLK0);
            if (DONE) break;
            if (edges == 1) chk("busy_calc", BUSY, 1'b1);
            CE0 = !(stall_len > 0 && edges >= stall_at && edges < stall_at + stall_len);
            @(posedge CLK0);
            edges++;
        end
        CE0 = 1'b1;
        chk("latency", edges, 19 + stall_len);
        chk("busy_at_done", BUSY, 1'b0);
        @(negedge CLK0);
        chk("done_one_cycle", DONE, 1'b0);
        START = 1'b0;
    endtask

    initial begin
        int dones;
        RST0 = 1'b1; CE0 = 1'b1; START = 1'b0; SIGNED = 1'b0;
        DIVIDEND = '0; DIVISOR = '0;

        add(36'd1000,        18'd7,       1'b0, 18'd142,   18'd6,     1'b0, 1'b0);
        add(36'hFFFFFFF9C,   18'd7,       1'b1, 18'h3FFF2, 18'h3FFFE, 1'b0, 1'b0);
        add(36'hFFFFE0000,   18'd1,       1'b1, 18'h20000, 18'h00000, 1'b0, 1'b0);
        add(36'd5,           18'd0,       1'b0, 18'h3FFFF, 18'd5,     1'b1, 1'b0);
        add(36'h000040000,   18'd1,       1'b0, 18'h3FFFF, 18'h00000, 1'b0, 1'b1);
        add(36'h800000000,   18'h3FFFF,   1'b1, 18'h1FFFF, 18'h00000, 1'b0, 1'b1);
        add(36'd100,         18'h3FFF9,   1'b1, 18'h3FFF2, 18'd2,     1'b0, 1'b0);
        add(36'hFFFFFFFF9,   18'd0,       1'b1, 18'h20000, 18'h3FFF9, 1'b1, 1'b0);
        add(36'h000020000,   18'd1,       1'b1, 18'h1FFFF, 18'h00000, 1'b0, 1'b1);
        add(36'h00001FFFF,   18'd1,       1'b1, 18'h1FFFF, 18'h00000, 1'b0, 1'b0);
        add(36'h00003FFFF,   18'd1,       1'b0, 18'h3FFFF, 18'h00000, 1'b0, 1'b0);
        add(36'hFFFFFFFFF,   18'h3FFFF,   1'b0, 18'h3FFFF, 18'h00000, 1'b0, 1'b1);
        add(36'hFFFFDFFFF,   18'd1,       1'b1, 18'h20000, 18'h00000, 1'b0, 1'b1);
        add(36'd0,           18'd5,       1'b0, 18'd0,     18'd0,     1'b0, 1'b0);
        add(36'hFFFFFFF9C,   18'h3FFF9,   1'b1, 18'd14,    18'h3FFFE, 1'b0, 1'b0);

        repeat (3) @(posedge CLK0);
        #2;
        chk("reset_busy", BUSY, 1'b0);
        chk("reset_done", DONE, 1'b0);
        chk("reset_outputs", {Q, R, DIV_ZERO, OVERFLOW, SIGNEDQ}, 39'd0);
        RST0 = 1'b0;
        cmp_en = 1'b1;

        foreach (vecs[i]) begin
            chk($sformatf("model_pin_%0d", i), model(vecs[i].a, vecs[i].b, vecs[i].s), vecs[i].e);
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, 0, 0, 1'b0);
        end

        run_op(36'd1000, 18'd7, 1'b0, 9, 5, 1'b0);
        run_op(36'd1000, 18'd7, 1'b0, 0, 0, 1'b1);

        // Abort mid-CALC with an asynchronous reset pulse.
        @(negedge CLK0);
        DIVIDEND = 36'd1000; DIVISOR = 18'd7; SIGNED = 1'b0; START = 1'b1;
        @(posedge CLK0);
        #1 START = 1'b0;
        repeat (10) @(posedge CLK0);
        #2 RST0 = 1'b1;
        #1;
        chk("abort_busy", BUSY, 1'b0);
        chk("abort_done", DONE, 1'b0);
        exp_q.delete();
        cur = '0;
        @(posedge CLK0);
        #2 RST0 = 1'b0;
        dones = 0;
        repeat (25) begin
            @(negedge CLK0);
            if (DONE) dones++;
        end
        chk("abort_no_done", dones, 0);
        chk("abort_q_r", {Q, R}, 36'd0);

        run_op(36'hFFFFFFF9C, 18'd7, 1'b1, 0, 0, 1'b0);

        repeat (3) @(negedge CLK0);
        chk("all_results_seen", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
